// File: rtl/i2c_pkg.sv
// Shared I2C definitions: controller FSM state encoding and buffer sizing.
package i2c_pkg;

   localparam int I2C_MAX_BYTES = 8;

   typedef enum logic [2:0] {
      IDLE,
      WAIT_LOW,
      RECV_BIT,
      ACK_DRIVE,
      ACK_HOLD
   } state_t;

endpackage

// File: rtl/i2c_line_sampler.sv
// Registers scl/sda and flags scl edges plus START/STOP conditions.
// I2C_SLAVE_INPUT_SYNC_EN inserts a 2-flop synchronizer ahead of the sampling stage.
module i2c_line_sampler
   import i2c_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic scl,
   input  logic sda_in,
   output logic sda_bit,
   output logic scl_rise,
   output logic scl_fall,
   output logic start_det,
   output logic stop_det
);

   logic scl_src, sda_src;
   logic scl_q, scl_d, sda_q, sda_d;
   logic scl_qq, scl_qq_d, sda_qq, sda_qq_d;

`ifdef I2C_SLAVE_INPUT_SYNC_EN
   logic [1:0] scl_sync_q, scl_sync_d, sda_sync_q, sda_sync_d;

   always_comb begin
      scl_sync_d = {scl_sync_q[0], scl};
      sda_sync_d = {sda_sync_q[0], sda_in};
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         scl_sync_q <= 2'b11;
         sda_sync_q <= 2'b11;
      end else begin
         scl_sync_q <= scl_sync_d;
         sda_sync_q <= sda_sync_d;
      end
   end

   assign scl_src = scl_sync_q[1];
   assign sda_src = sda_sync_q[1];
`else
   assign scl_src = scl;
   assign sda_src = sda_in;
`endif

   always_comb begin
      scl_d    = scl_src;
      sda_d    = sda_src;
      scl_qq_d = scl_q;
      sda_qq_d = sda_q;
   end

   // Idle bus is high on both lines, so history resets to 1 to avoid false edges.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         scl_q  <= 1'b1;
         sda_q  <= 1'b1;
         scl_qq <= 1'b1;
         sda_qq <= 1'b1;
      end else begin
         scl_q  <= scl_d;
         sda_q  <= sda_d;
         scl_qq <= scl_qq_d;
         sda_qq <= sda_qq_d;
      end
   end

   assign sda_bit   = sda_q;
   assign scl_rise  = scl_q & ~scl_qq;
   assign scl_fall  = ~scl_q & scl_qq;
   assign start_det = scl_q & scl_qq & sda_qq & ~sda_q;
   assign stop_det  = scl_q & scl_qq & ~sda_qq & sda_q;

endmodule

// File: rtl/i2c_simple_slave.sv
// Write-only I2C receiver: captures LSB-first bytes into a buffer, ACKs while room remains.
// I2C_SLAVE_INPUT_SYNC_EN adds a 2-clk input synchronizer inside i2c_line_sampler.
module i2c_simple_slave
   import i2c_pkg::*;
#(
   parameter int MAX_BYTES = I2C_MAX_BYTES
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            scl,
   input  logic            sda_in,
   output logic            sda_out,
   output logic            sda_out_en,
   output logic [7:0][7:0] rx_data,
   output logic [3:0]      rx_count,
   output logic [7:0]      rx_byte,
   output logic            byte_valid,
   output logic            frame_done,
   output logic            busy,
   output logic            overflow
);

   logic sda_bit, scl_rise, scl_fall, start_det, stop_det;

   i2c_line_sampler u_sampler (
      .clk       (clk),
      .rst_n     (rst_n),
      .scl       (scl),
      .sda_in    (sda_in),
      .sda_bit   (sda_bit),
      .scl_rise  (scl_rise),
      .scl_fall  (scl_fall),
      .start_det (start_det),
      .stop_det  (stop_det)
   );

   state_t          state_q, state_d;
   logic [3:0]      bit_cnt_q, bit_cnt_d;
   logic [7:0]      shift_q, shift_d;
   logic [7:0][7:0] rx_data_q, rx_data_d;
   logic [3:0]      rx_count_q, rx_count_d;
   logic [7:0]      rx_byte_q, rx_byte_d;
   logic            byte_valid_q, byte_valid_d;
   logic            frame_done_q, frame_done_d;
   logic            overflow_q, overflow_d;
   logic            ack_q, ack_d;

   always_comb begin
      state_d      = state_q;
      bit_cnt_d    = bit_cnt_q;
      shift_d      = shift_q;
      rx_data_d    = rx_data_q;
      rx_count_d   = rx_count_q;
      rx_byte_d    = rx_byte_q;
      byte_valid_d = 1'b0;
      frame_done_d = 1'b0;
      overflow_d   = overflow_q;
      ack_d        = ack_q;

      // Bus conditions override the byte FSM; a partial byte simply dies with bit_cnt.
      if (stop_det) begin
         frame_done_d = (state_q != IDLE);
         state_d      = IDLE;
         bit_cnt_d    = 4'd0;
      end else if (start_det) begin
         state_d    = WAIT_LOW;
         bit_cnt_d  = 4'd0;
         rx_count_d = 4'd0;
         overflow_d = 1'b0;
      end else begin
         case (state_q)
            WAIT_LOW: begin
               if (scl_fall) begin
                  state_d   = RECV_BIT;
                  bit_cnt_d = 4'd0;
               end
            end
            RECV_BIT: begin
               if (scl_rise && bit_cnt_q < 4'd8) begin
                  shift_d[bit_cnt_q[2:0]] = sda_bit;
                  bit_cnt_d = bit_cnt_q + 4'd1;
                  if (bit_cnt_q == 4'd7) begin
                     rx_byte_d    = shift_d;
                     byte_valid_d = 1'b1;
                     if (rx_count_q < 4'(MAX_BYTES)) begin
                        rx_data_d[rx_count_q[2:0]] = shift_d;
                        rx_count_d = rx_count_q + 4'd1;
                        ack_d      = 1'b1;
                     end else begin
                        ack_d      = 1'b0;
                        overflow_d = 1'b1;
                     end
                  end
               end else if (scl_fall && bit_cnt_q == 4'd8) begin
                  state_d = ACK_DRIVE;
               end
            end
            ACK_DRIVE: begin
               if (scl_rise) state_d = ACK_HOLD;
            end
            ACK_HOLD: begin
               if (scl_fall) begin
                  state_d   = RECV_BIT;
                  bit_cnt_d = 4'd0;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         bit_cnt_q    <= 4'd0;
         shift_q      <= 8'd0;
         rx_data_q    <= '0;
         rx_count_q   <= 4'd0;
         rx_byte_q    <= 8'd0;
         byte_valid_q <= 1'b0;
         frame_done_q <= 1'b0;
         overflow_q   <= 1'b0;
         ack_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         bit_cnt_q    <= bit_cnt_d;
         shift_q      <= shift_d;
         rx_data_q    <= rx_data_d;
         rx_count_q   <= rx_count_d;
         rx_byte_q    <= rx_byte_d;
         byte_valid_q <= byte_valid_d;
         frame_done_q <= frame_done_d;
         overflow_q   <= overflow_d;
         ack_q        <= ack_d;
      end
   end

   assign sda_out_en = ack_q && (state_q == ACK_DRIVE || state_q == ACK_HOLD);
   assign sda_out    = ~sda_out_en;
   assign rx_data    = rx_data_q;
   assign rx_count   = rx_count_q;
   assign rx_byte    = rx_byte_q;
   assign byte_valid = byte_valid_q;
   assign frame_done = frame_done_q;
   assign busy       = (state_q != IDLE);
   assign overflow   = overflow_q;

endmodule

// File: tb/tb_i2c_simple_slave.sv
// Bench for i2c_simple_slave: bus-level master tasks, a byte table, and hand-written corner sequences.
module tb_i2c_simple_slave;

`ifdef I2C_SLAVE_INPUT_SYNC_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 0;
`endif
   localparam int H = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic scl = 1'b1;
   logic sda = 1'b1;

   logic            sda_out, sda_out_en, byte_valid, frame_done, busy, overflow;
   logic [7:0][7:0] rx_data;
   logic [3:0]      rx_count;
   logic [7:0]      rx_byte;
   logic            sda_out2, sda_out_en2, byte_valid2, frame_done2, busy2, overflow2;
   logic [7:0][7:0] rx_data2;
   logic [3:0]      rx_count2;
   logic [7:0]      rx_byte2;

   i2c_simple_slave #(.MAX_BYTES(8)) dut (
      .clk(clk), .rst_n(rst_n), .scl(scl), .sda_in(sda),
      .sda_out(sda_out), .sda_out_en(sda_out_en), .rx_data(rx_data),
      .rx_count(rx_count), .rx_byte(rx_byte), .byte_valid(byte_valid),
      .frame_done(frame_done), .busy(busy), .overflow(overflow)
   );

   i2c_simple_slave #(.MAX_BYTES(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .scl(scl), .sda_in(sda),
      .sda_out(sda_out2), .sda_out_en(sda_out_en2), .rx_data(rx_data2),
      .rx_count(rx_count2), .rx_byte(rx_byte2), .byte_valid(byte_valid2),
      .frame_done(frame_done2), .busy(busy2), .overflow(overflow2)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int bv_cnt = 0, bv2_cnt = 0, fd_cnt = 0;

   always @(posedge clk) begin
      if (byte_valid)  bv_cnt++;
      if (byte_valid2) bv2_cnt++;
      if (frame_done)  fd_cnt++;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic wait_h();
      repeat (H) @(negedge clk);
   endtask

   // Works both from idle and as a repeated start with scl low.
   task automatic i2c_start();
      sda = 1'b1; wait_h();
      scl = 1'b1; wait_h();
      sda = 1'b0; wait_h();
      scl = 1'b0; wait_h();
   endtask

   task automatic i2c_stop();
      sda = 1'b0; wait_h();
      scl = 1'b1; wait_h();
      sda = 1'b1; wait_h();
   endtask

   task automatic send_bits(input logic [7:0] dat, input int n, input bit measure);
      int lat;
      bit found;
      for (int i = 0; i < n; i++) begin
         sda = dat[i];
         wait_h();
         scl = 1'b1;
         if (measure && i == 7) begin
            lat = 0;
            found = 0;
            for (int k = 1; k <= 20; k++) begin
               @(posedge clk); #1;
               if (byte_valid && !found) begin
                  found = 1;
                  lat = k;
               end
            end
            @(negedge clk);
            chk("byte_valid_latency", lat, 2 + LAT);
         end else begin
            wait_h();
         end
         scl = 1'b0;
         wait_h();
      end
   endtask

   task automatic ack_bit(output logic a8, output logic a2);
      sda = 1'b1; wait_h();
      scl = 1'b1; wait_h();
      a8 = sda_out_en && !sda_out;
      a2 = sda_out_en2 && !sda_out2;
      scl = 1'b0; wait_h();
   endtask

   typedef struct {
      logic [7:0] dat;
      logic       ack8;
      logic       ack2;
      logic [3:0] cnt8;
      logic [3:0] cnt2;
   } vec_t;

   vec_t tv[11];

   initial begin
      logic a8, a2;
      int fd0;

      tv[0] = '{8'hA5, 1'b1, 1'b1, 4'd1, 4'd1};
      tv[1] = '{8'h3C, 1'b1, 1'b1, 4'd2, 4'd2};
      tv[2] = '{8'hFF, 1'b1, 1'b0, 4'd3, 4'd2};
      tv[3]  = '{8'h00, 1'b1, 1'b1, 4'd1, 4'd1};
      tv[4]  = '{8'h01, 1'b1, 1'b1, 4'd2, 4'd2};
      tv[5]  = '{8'h02, 1'b1, 1'b0, 4'd3, 4'd2};
      tv[6]  = '{8'h03, 1'b1, 1'b0, 4'd4, 4'd2};
      tv[7]  = '{8'h04, 1'b1, 1'b0, 4'd5, 4'd2};
      tv[8]  = '{8'h05, 1'b1, 1'b0, 4'd6, 4'd2};
      tv[9]  = '{8'h06, 1'b1, 1'b0, 4'd7, 4'd2};
      tv[10] = '{8'h07, 1'b1, 1'b0, 4'd8, 4'd2};

      repeat (3) @(negedge clk);
      chk("rst_sda_out_en", sda_out_en, 0);
      chk("rst_sda_out", sda_out, 1);
      chk("rst_busy", busy, 0);
      chk("rst_rx_count", rx_count, 0);
      chk("rst_rx_byte", rx_byte, 0);
      chk("rst_overflow", overflow, 0);
      rst_n = 1'b1;
      wait_h();

      // Two frames from the table: 3 bytes, then 8 bytes.
      for (int i = 0; i < 11; i++) begin
         if (i == 0 || i == 3) begin
            i2c_start();
            chk($sformatf("busy_after_start_%0d", i), busy, 1);
         end
         send_bits(tv[i].dat, 8, 1'b1);
         chk($sformatf("rx_byte_%0d", i), rx_byte, tv[i].dat);
         chk($sformatf("rx_count_%0d", i), rx_count, tv[i].cnt8);
         chk($sformatf("rx_count2_%0d", i), rx_count2, tv[i].cnt2);
         ack_bit(a8, a2);
         chk($sformatf("ack_%0d", i), a8, tv[i].ack8);
         chk($sformatf("ack2_%0d", i), a2, tv[i].ack2);
         chk($sformatf("released_%0d", i), sda_out_en | sda_out_en2, 0);
         if (i == 2 || i == 10) begin
            fd0 = fd_cnt;
            i2c_stop();
            wait_h();
            chk($sformatf("frame_done_%0d", i), fd_cnt - fd0, 1);
            chk($sformatf("busy_after_stop_%0d", i), busy, 0);
            chk($sformatf("overflow_%0d", i), overflow, 0);
            chk($sformatf("overflow2_%0d", i), overflow2, 1);
         end
         if (i == 2) begin
            chk("f1_rx_data0", rx_data[0], 8'hA5);
            chk("f1_rx_data1", rx_data[1], 8'h3C);
            chk("f1_rx_data2", rx_data[2], 8'hFF);
            chk("f1_bv_count", bv_cnt, 3);
            chk("f1_bv2_count", bv2_cnt, 3);
         end
      end
      chk("f2_rx_data0", rx_data[0], 8'h00);
      chk("f2_rx_data7", rx_data[7], 8'h07);
      chk("f2_bv_count", bv_cnt, 11);

      // Repeated start after 4 bits of the second byte.
      i2c_start();
      send_bits(8'h11, 8, 1'b0);
      ack_bit(a8, a2);
      send_bits(8'h5A, 4, 1'b0);
      i2c_start();
      chk("rs_rx_count", rx_count, 0);
      chk("rs_busy", busy, 1);
      chk("rs_overflow", overflow, 0);
      send_bits(8'h22, 8, 1'b0);
      ack_bit(a8, a2);
      chk("rs_ack", a8, 1);
      chk("rs_rx_count_after", rx_count, 1);
      chk("rs_rx_data0", rx_data[0], 8'h22);
      chk("rs_rx_data1_held", rx_data[1], 8'h01);
      fd0 = fd_cnt;
      i2c_stop();
      wait_h();
      chk("rs_frame_done", fd_cnt - fd0, 1);

      // Stop in the middle of a byte.
      i2c_start();
      send_bits(8'h33, 8, 1'b0);
      ack_bit(a8, a2);
      send_bits(8'h0F, 3, 1'b0);
      fd0 = fd_cnt;
      i2c_stop();
      wait_h();
      chk("ms_rx_count", rx_count, 1);
      chk("ms_rx_byte", rx_byte, 8'h33);
      chk("ms_busy", busy, 0);
      chk("ms_frame_done", fd_cnt - fd0, 1);

      // Reset in the middle of a byte.
      i2c_start();
      send_bits(8'h44, 8, 1'b0);
      ack_bit(a8, a2);
      send_bits(8'hC3, 4, 1'b0);
      fd0 = fd_cnt;
      rst_n = 1'b0;
      @(posedge clk); #1;
      chk("mr_busy", busy, 0);
      chk("mr_rx_count", rx_count, 0);
      chk("mr_rx_byte", rx_byte, 0);
      chk("mr_rx_data", rx_data, 64'd0);
      chk("mr_sda_out_en", sda_out_en, 0);
      chk("mr_sda_out", sda_out, 1);
      chk("mr_overflow", overflow, 0);
      chk("mr_byte_valid", byte_valid, 0);
      @(negedge clk);
      scl = 1'b1;
      sda = 1'b1;
      wait_h();
      rst_n = 1'b1;
      wait_h();
      chk("mr_no_frame_done", fd_cnt - fd0, 0);
      chk("mr_busy_after", busy, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
